// File: rtl/des_core_iter.sv
// des_core_iter
// Iterative DES engine that encrypts or decrypts one 64-bit block per
// transaction. ROUNDS_PER_CYCLE rounds are chained combinationally per clock,
// so a block takes 16/ROUNDS_PER_CYCLE RUN cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = encrypt, 1 = decrypt (captured when a block is accepted)
//   in_valid   in/key/mode are valid
//   in_ready   core can accept a block this cycle
//   in         input block, bit 63 = FIPS bit 1
//   key        64-bit key, parity bits ignored
//   out_valid  out holds a finished result
//   out_ready  sink takes out this cycle
//   out        result block
//   busy       high while a block is in flight or waiting in DONE
module des_core_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic        busy
);

    if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_rounds
        $error("des_core_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Permutation tables hold 1-based FIPS bit numbers, bit 1 being the MSB.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // S-boxes, row-major: entry index = row*16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
          4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
          4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
          4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
        '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
          4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
          4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
          4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
        '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
          4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
          4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
        '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
          4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
          4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
          4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
        '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
          4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
          4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
          4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
        '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
          4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
          4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
          4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
        '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
          4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
          4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
          4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
        '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
          4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
          4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
          4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] expand_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    // Feistel function: each 6-bit group picks its S-box row from its outer
    // bits and its column from the inner four.
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        x = expand_e(r) ^ k;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            b = 6'(x >> (42 - 6 * n));
            s = {s[27:0], SBOX[3'(n)][{b[5], b[0], b[4:1]}]};
        end
        return perm_p(s);
    endfunction

    // Rounds 0, 1, 8 and 15 shift by one; every other round shifts by two.
    function automatic logic shift_is_two(input logic [3:0] i);
        return !((i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15));
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic [63:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] l_n, r_n;
    logic [27:0] c_n, d_n;
    logic        accept;
    logic        last_cycle;
    logic [63:0] ip_in;
    logic [55:0] pc1_key;

    assign ip_in      = perm_ip(in);
    assign pc1_key    = perm_pc1(key);
    assign last_cycle = (5'(rnd_q) + 5'(ROUNDS_PER_CYCLE)) == 5'd16;

    // Round datapath: ROUNDS_PER_CYCLE rounds chained with consecutive round
    // numbers. Decryption takes the subkey from the current C/D before rotating
    // right, so its first round sees K16 straight from the PC1 registers.
    always_comb begin
        logic [31:0] lt, rt, ft;
        logic [27:0] ct, dt;
        logic [47:0] kt;
        logic [3:0]  ri;
        lt = l_q;
        rt = r_q;
        ct = c_q;
        dt = d_q;
        ft = '0;
        kt = '0;
        ri = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            ri = rnd_q + 4'(j);
            if (!mode_q) begin
                ct = rotl28(ct, shift_is_two(ri));
                dt = rotl28(dt, shift_is_two(ri));
            end
            kt = perm_pc2({ct, dt});
            ft = feistel(rt, kt);
            {lt, rt} = {rt, lt ^ ft};
            if (mode_q) begin
                ct = rotr28(ct, shift_is_two(4'd15 - ri));
                dt = rotr28(dt, shift_is_two(4'd15 - ri));
            end
        end
        l_n = lt;
        r_n = rt;
        c_n = ct;
        d_n = dt;
    end

    // Control: acceptance is legal in IDLE or in DONE while the sink takes the
    // current result, which lets a new block start on the hand-off edge.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        mode_d      = mode_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept      = in_valid && in_ready;

        case (state_q)
            IDLE: begin
            end
            RUN: begin
                l_d = l_n;
                r_d = r_n;
                c_d = c_n;
                d_d = d_n;
                if (last_cycle) begin
                    // Final swap undone by presenting R16 before L16.
                    out_d       = perm_fp({r_n, l_n});
                    out_valid_d = 1'b1;
                    rnd_d       = '0;
                    state_d     = DONE;
                end else begin
                    rnd_d = rnd_q + 4'(ROUNDS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            {l_d, r_d}  = ip_in;
            {c_d, d_d}  = pc1_key;
            mode_d      = mode;
            rnd_d       = '0;
            out_valid_d = 1'b0;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_des_core_iter.sv
// tb_des_core_iter
// Drives five des_core_iter instances, one per legal ROUNDS_PER_CYCLE
// (instance g unrolls 2**g rounds). Inputs in/key/mode are shared; each
// instance has its own handshake. Expected results are queued at acceptance
// and compared when out_valid appears.
module tb_des_core_iter;

    localparam int NDUT = 5;

    typedef struct {
        logic [63:0] exp;
        logic        known;
        string       tag;
    } sb_t;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [63:0]     din;
    logic [63:0]     key;
    logic [NDUT-1:0] in_valid;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] out_ready;
    logic [NDUT-1:0] busy;
    logic [63:0]     dout [NDUT];

    sb_t sb_q[$];
    int  checks;
    int  errors;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_core_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mode      (mode),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in        (din),
            .key       (key),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out       (dout[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present a block to one instance and hold it until accepted. Call just
    // after a falling edge; returns 1 time unit after the acceptance edge.
    task automatic applyStimulus(input int idx, input logic m, input logic [63:0] data,
                                 input logic [63:0] k, input logic known,
                                 input logic [63:0] exp, input string tag);
        int  cnt;
        sb_t e;
        mode = m;
        din = data;
        key = k;
        in_valid[idx] = 1'b1;
        #1;
        cnt = 0;
        while (!in_ready[idx] && cnt < 50) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        checkOutput({tag, " in_ready"}, 64'(in_ready[idx]), 64'd1);
        @(posedge clk);
        e.exp = exp;
        e.known = known;
        e.tag = tag;
        sb_q.push_back(e);
        #1;
        in_valid[idx] = 1'b0;
        out_ready[idx] = 1'b0;
        mode = ~m;
        din = ~data;
        key = ~k;
        checkOutput({tag, " busy after accept"}, 64'(busy[idx]), 64'd1);
        checkOutput({tag, " in_ready after accept"}, 64'(in_ready[idx]), 64'd0);
        checkOutput({tag, " out_valid after accept"}, 64'(out_valid[idx]), 64'd0);
    endtask

    // Wait for the result, scrambling inputs every cycle, check latency and
    // value, optionally hold it under backpressure, then optionally release it.
    task automatic collectResult(input int idx, input int hold, input logic release_out,
                                 output logic [63:0] got);
        int  cnt;
        sb_t e;
        cnt = 0;
        while (!out_valid[idx] && cnt < 40) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            mode = 1'($urandom);
            din = {$urandom, $urandom};
            key = {$urandom, $urandom};
        end
        checkOutput($sformatf("dut%0d latency", idx), 64'(cnt), 64'(16 >> idx));
        got = dout[idx];
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard entry present", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            if (e.known) checkOutput($sformatf("dut%0d %s", idx, e.tag), got, e.exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold out", dout[idx], got);
            checkOutput("hold out_valid", 64'(out_valid[idx]), 64'd1);
            checkOutput("hold in_ready", 64'(in_ready[idx]), 64'd0);
        end
        if (release_out) begin
            out_ready[idx] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[idx] = 1'b0;
            checkOutput("release out_valid", 64'(out_valid[idx]), 64'd0);
            checkOutput("release busy", 64'(busy[idx]), 64'd0);
            checkOutput("release out retained", dout[idx], got);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] got;
        logic [63:0] ct;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        mode = 1'b0;
        din = '0;
        key = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("dut%0d reset out", i), dout[i], 64'h0);
            checkOutput($sformatf("dut%0d reset out_valid", i), 64'(out_valid[i]), 64'd0);
            checkOutput($sformatf("dut%0d reset busy", i), 64'(busy[i]), 64'd0);
            checkOutput($sformatf("dut%0d reset in_ready", i), 64'(in_ready[i]), 64'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer encrypt, then 10 cycles of backpressure, then a
        // known-answer decrypt accepted on the same edge as the hand-off.
        applyStimulus(0, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1,
                      64'h85E813540F0AB405, "kat enc");
        collectResult(0, 10, 1'b0, got);
        out_ready[0] = 1'b1;
        applyStimulus(0, 1'b1, 64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1,
                      64'h8787878787878787, "kat dec back-to-back");
        collectResult(0, 0, 1'b1, got);

        // Every unroll factor: parity bits ignored, then an encrypt/decrypt round trip.
        for (int i = 0; i < NDUT; i++) begin
            applyStimulus(i, 1'b0, 64'h0123456789ABCDEF,
                          64'h133457799BBCDFF1 ^ 64'h0101010101010101, 1'b1,
                          64'h85E813540F0AB405, "parity flipped enc");
            collectResult(i, 0, 1'b1, got);
            applyStimulus(i, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hb5ff63141a19e1a9, 1'b0,
                          64'h0, "round trip enc");
            collectResult(i, 0, 1'b1, ct);
            applyStimulus(i, 1'b1, ct, 64'hb5ff63141a19e1a9, 1'b1,
                          64'hFFFFFFFFFFFFFFFF, "round trip dec");
            collectResult(i, 0, 1'b1, got);
        end

        // Reset asserted asynchronously once round counter reaches 7.
        applyStimulus(0, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1,
                      64'h85E813540F0AB405, "reset victim");
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrun reset out", dout[0], 64'h0);
        checkOutput("midrun reset out_valid", 64'(out_valid[0]), 64'd0);
        checkOutput("midrun reset busy", 64'(busy[0]), 64'd0);
        checkOutput("midrun reset in_ready", 64'(in_ready[0]), 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1,
                      64'h8787878787878787, "after reset dec");
        collectResult(0, 0, 1'b1, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
